// File: rtl/key_event_ctrl.sv
// Turns one debounced key (press pulse plus level) into click, double-click,
// long-press and auto-repeat event pulses for the application logic.
module key_event_ctrl #(
    parameter logic [25:0] LONG_CNT   = 26'd50_000_000,
    parameter logic [25:0] DCLK_CNT   = 26'd15_000_000,
    parameter logic [25:0] REPEAT_CNT = 26'd10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_flag,
    input  logic key_state,
    input  logic repeat_en,
    output logic ev_click,
    output logic ev_dclick,
    output logic ev_long,
    output logic ev_repeat,
    output logic busy
);

    localparam int unsigned CNT_W = 26;

    localparam logic [CNT_W-1:0] LONG_LAST = LONG_CNT - CNT_W'(1);
    localparam logic [CNT_W-1:0] DCLK_LAST = DCLK_CNT - CNT_W'(1);
    localparam logic [CNT_W-1:0] REP_LAST  = REPEAT_CNT - CNT_W'(1);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        PRESS1 = 5'b00010,
        WAIT2  = 5'b00100,
        PRESS2 = 5'b01000,
        LONG   = 5'b10000
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ks_d;
    logic             rel;

    // Release is seen as a falling edge of the debounced level.
    assign rel = ks_d & ~key_state;

    // Gesture sequencer; event pulses default low and busy tracks the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ks_d      <= 1'b0;
            ev_click  <= 1'b0;
            ev_dclick <= 1'b0;
            ev_long   <= 1'b0;
            ev_repeat <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ks_d      <= key_state;
            ev_click  <= 1'b0;
            ev_dclick <= 1'b0;
            ev_long   <= 1'b0;
            ev_repeat <= 1'b0;

            case (state)
                IDLE: begin
                    if (key_flag) begin
                        state <= PRESS1;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                PRESS1: begin
                    // Release wins over a coincident long timeout.
                    if (rel) begin
                        state <= WAIT2;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state   <= LONG;
                        cnt     <= '0;
                        ev_long <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT2: begin
                    // A second press on the last window cycle still counts as a double click.
                    if (key_flag) begin
                        state <= PRESS2;
                    end else if (cnt == DCLK_LAST) begin
                        state    <= IDLE;
                        ev_click <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESS2: begin
                    if (rel) begin
                        state     <= IDLE;
                        ev_dclick <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                LONG: begin
                    if (rel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (repeat_en) begin
                        if (cnt == REP_LAST) begin
                            ev_repeat <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: gesture table, randomized gestures
// against a timing-arithmetic model, and mid-gesture reset sequences.
module tb_key_event_ctrl;

    localparam int LC   = 100;
    localparam int DC   = 40;
    localparam int RC   = 20;
    localparam int MAXC = 65536;
    localparam int TAIL = 45;

    logic clk = 1'b0;
    logic rst;
    logic key_flag;
    logic key_state;
    logic repeat_en;
    logic ev_click;
    logic ev_dclick;
    logic ev_long;
    logic ev_repeat;
    logic busy;

    always #5 clk = ~clk;

    key_event_ctrl #(
        .LONG_CNT  (26'd100),
        .DCLK_CNT  (26'd40),
        .REPEAT_CNT(26'd20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_flag (key_flag),
        .key_state(key_state),
        .repeat_en(repeat_en),
        .ev_click (ev_click),
        .ev_dclick(ev_dclick),
        .ev_long  (ev_long),
        .ev_repeat(ev_repeat),
        .busy     (busy)
    );

    // Observed/expected per cycle: {busy, click, dclick, long, repeat}
    logic [4:0] obs  [MAXC];
    logic [4:0] expv [MAXC];
    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int   h1;
        int   j;
        int   h2;
        logic rep;
        int   kind;    // 0 click, 1 dclick, 2 long
        int   at;      // offset of that event from the first key_flag cycle
        int   nrep;
        int   busy_n;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [4:0] outs();
        return {busy, ev_click, ev_dclick, ev_long, ev_repeat};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick(input logic kf, input logic ks, input logic re);
        @(negedge clk);
        key_flag  = kf;
        key_state = ks;
        repeat_en = re;
        @(posedge clk);
        #1;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d want below %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        obs[cyc] = outs();
        cyc++;
    endtask

    task automatic drive_gesture(input int h1, input int j, input int h2, input logic rep,
                                 input bit noise, output int f);
        f = cyc;
        tick(1'b1, 1'b0, rep);
        for (int i = 0; i < h1; i++) tick(noise && ($urandom_range(0, 15) == 0), 1'b1, rep);
        if (h2 > 0) begin
            for (int i = 0; i < j; i++) tick(1'b0, 1'b0, rep);
            tick(1'b1, 1'b0, rep);
            for (int i = 0; i < h2; i++) tick(noise && ($urandom_range(0, 15) == 0), 1'b1, rep);
        end
        for (int i = 0; i < TAIL; i++) tick(1'b0, 1'b0, rep);
    endtask

    // Expected outputs from gesture durations: r1 is the first cycle the key reads released.
    task automatic model(input int s, input int f, input int h1, input int j, input int h2,
                         input logic rep, input int e);
        int r1;
        int last;
        for (int i = s; i < e; i++) expv[i] = 5'b0;
        r1 = f + h1 + 1;
        if (h1 >= LC) begin
            last = r1;
            expv[f + LC][1] = 1'b1;
            if (rep) for (int t = f + LC + RC; t < r1; t += RC) expv[t][0] = 1'b1;
        end else if (h2 == 0) begin
            last = r1 + DC;
            expv[last][3] = 1'b1;
        end else begin
            last = r1 + j + h2 + 1;
            expv[last][2] = 1'b1;
        end
        for (int i = f; i < last; i++) expv[i][4] = 1'b1;
    endtask

    task automatic check_window(input string name, input int s, input int e);
        for (int i = s; i < e; i++) check($sformatf("%s_cyc%0d", name, i), 32'(obs[i]), 32'(expv[i]));
    endtask

    task automatic modeled_gesture(input string name, input int idle, input int h1, input int j,
                                   input int h2, input logic rep, input bit noise);
        int s;
        int f;
        s = cyc;
        for (int i = 0; i < idle; i++) tick(1'b0, 1'b0, rep);
        drive_gesture(h1, j, h2, rep, noise, f);
        model(s, f, h1, j, h2, rep, cyc);
        check_window(name, s, cyc);
    endtask

    task automatic quiet_check(input string name, input int s, input int e);
        int nz;
        nz = 0;
        for (int i = s; i < e; i++) if (obs[i] != 5'b0) nz++;
        check(name, 32'(nz), 32'd0);
    endtask

    initial begin
        int f;
        int s;
        int nc, nd, nl, nr, nb, pos;
        int kind, h1, j, h2;
        logic rep;

        tbl[0] = '{h1: 30,  j: 0,  h2: 0,   rep: 1'b0, kind: 0, at: 71,  nrep: 0,  busy_n: 71};
        tbl[1] = '{h1: 30,  j: 10, h2: 150, rep: 1'b0, kind: 1, at: 192, nrep: 0,  busy_n: 192};
        tbl[2] = '{h1: 300, j: 0,  h2: 0,   rep: 1'b1, kind: 2, at: 100, nrep: 10, busy_n: 301};
        tbl[3] = '{h1: 300, j: 0,  h2: 0,   rep: 1'b0, kind: 2, at: 100, nrep: 0,  busy_n: 301};
        tbl[4] = '{h1: 99,  j: 0,  h2: 0,   rep: 1'b1, kind: 0, at: 140, nrep: 0,  busy_n: 140};
        tbl[5] = '{h1: 100, j: 0,  h2: 0,   rep: 1'b1, kind: 2, at: 100, nrep: 0,  busy_n: 101};
        tbl[6] = '{h1: 30,  j: 40, h2: 5,   rep: 1'b0, kind: 1, at: 77,  nrep: 0,  busy_n: 77};
        tbl[7] = '{h1: 219, j: 0,  h2: 0,   rep: 1'b1, kind: 2, at: 100, nrep: 5,  busy_n: 220};

        rst       = 1'b0;
        key_flag  = 1'b0;
        key_state = 1'b0;
        repeat_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(outs()), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int r = 0; r < 8; r++) begin
            drive_gesture(tbl[r].h1, tbl[r].j, tbl[r].h2, tbl[r].rep, 1'b0, f);
            nc = 0; nd = 0; nl = 0; nr = 0; nb = 0; pos = -1;
            for (int i = f; i < cyc; i++) begin
                if (obs[i][3]) nc++;
                if (obs[i][2]) nd++;
                if (obs[i][1]) nl++;
                if (obs[i][0]) nr++;
                if (obs[i][4]) nb++;
                if (pos < 0 && obs[i][3 - tbl[r].kind]) pos = i - f;
            end
            check($sformatf("row%0d_click_dclick_long_counts", r), 32'(nc * 100 + nd * 10 + nl),
                  (tbl[r].kind == 0) ? 32'd100 : (tbl[r].kind == 1) ? 32'd10 : 32'd1);
            check($sformatf("row%0d_event_offset", r), 32'(pos), 32'(tbl[r].at));
            check($sformatf("row%0d_repeat_count", r), 32'(nr), 32'(tbl[r].nrep));
            check($sformatf("row%0d_busy_cycles", r), 32'(nb), 32'(tbl[r].busy_n));
        end

        for (int g = 0; g < 30; g++) begin
            kind = int'($urandom_range(0, 2));
            rep  = 1'($urandom_range(0, 1));
            j = 0;
            h2 = 0;
            if (kind == 2) begin
                h1 = int'($urandom_range(LC, 250));
            end else begin
                h1 = int'($urandom_range(1, LC - 1));
                if (kind == 1) begin
                    j  = int'($urandom_range(1, DC));
                    h2 = int'($urandom_range(1, 120));
                end
            end
            modeled_gesture($sformatf("rand%0d", g), int'($urandom_range(0, 4)), h1, j, h2, rep, 1'b1);
        end

        // Reset while in LONG: immediate clear, no event, stale release ignored.
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 150; i++) tick(1'b0, 1'b1, 1'b1);
        check("long_busy_before_reset", 32'(obs[cyc - 1][4]), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("reset_async_in_long", 32'(outs()), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        s = cyc;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 50; i++) tick(1'b0, 1'b0, 1'b1);
        quiet_check("quiet_after_long_reset", s, cyc);
        modeled_gesture("click_after_long_reset", 0, 30, 0, 0, 1'b0, 1'b0);

        // Reset while in WAIT2: the pending click must never appear.
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0);
        check("wait2_busy_before_reset", 32'(obs[cyc - 1][4]), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("reset_async_in_wait2", 32'(outs()), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        s = cyc;
        for (int i = 0; i < 60; i++) tick(1'b0, 1'b0, 1'b0);
        quiet_check("quiet_after_wait2_reset", s, cyc);
        modeled_gesture("click_after_wait2_reset", 0, 30, 0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
